// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor
// Watches CHANNELS independent bit-serial HDLC lines. For each line it finds
// flags, aborts and stuffed zeros, tracks frame sync, and counts destuffed
// bits to report the end of each frame, misaligned payloads and oversize
// frames. Error events from all lines are summed into one saturating counter.
//
// Parameters:
//   CHANNELS  - number of monitored lines
//   MAX_BYTES - largest legal payload in bytes
//   ERR_W     - width of ErrCnt
//
// Ports:
//   Clk         in   sole clock, posedge
//   Rst         in   synchronous active-high reset
//   BitEn       in   [CHANNELS] bit strobe; Line is sampled only when set
//   Line        in   [CHANNELS] serial data
//   FlagDetect  out  [CHANNELS] pulse: 01111110 received
//   AbortDetect out  [CHANNELS] pulse: seventh 1 after a 0
//   IdleDetect  out  [CHANNELS] pulse: every 15 ones while hunting
//   ZeroDetect  out  [CHANNELS] pulse: stuffed zero removed
//   EoF         out  [CHANNELS] pulse: closing flag of a frame
//   AlignErr    out  [CHANNELS] pulse with EoF: payload not whole bytes
//   ValidFrame  out  [CHANNELS] line is in FRAME
//   Overflow    out  [CHANNELS] sticky while the current frame is oversize
//   ErrCnt      out  [ERR_W]    saturating error count, all lines
//
// Build option: define HDLC_MON_IDLE_EN to enable IdleDetect; otherwise it is
// tied low and the ones-run counter only needs to reach 7.
//
// state | meaning
// HUNT  | no sync; waiting for a flag
// OPEN  | flag seen; fewer than 8 destuffed bits since it
// FRAME | 8 or more destuffed bits since the last flag; frame in progress

module hdlc_line_monitor #(
    parameter int CHANNELS  = 2,
    parameter int MAX_BYTES = 128,
    parameter int ERR_W     = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [CHANNELS-1:0] BitEn,
    input  logic [CHANNELS-1:0] Line,
    output logic [CHANNELS-1:0] FlagDetect,
    output logic [CHANNELS-1:0] AbortDetect,
    output logic [CHANNELS-1:0] IdleDetect,
    output logic [CHANNELS-1:0] ZeroDetect,
    output logic [CHANNELS-1:0] EoF,
    output logic [CHANNELS-1:0] AlignErr,
    output logic [CHANNELS-1:0] ValidFrame,
    output logic [CHANNELS-1:0] Overflow,
    output logic [ERR_W-1:0]    ErrCnt
);

    // The counter also holds the 8 bits of the closing flag, hence the +1 byte.
    localparam int              LIMIT     = (MAX_BYTES + 1) * 8;
    localparam int              CNT_W     = $clog2(LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_OPEN  = CNT_W'(8);
`ifdef HDLC_MON_IDLE_EN
    localparam int              ONES_W    = 4;
`else
    localparam int              ONES_W    = 3;
`endif
    localparam logic [ONES_W-1:0] ONES_MAX = '1;
    localparam int              SUM_W     = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        OPEN  = 2'd1,
        FRAME = 2'd2
    } state_t;

    logic [CHANNELS-1:0] err_ev;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t            state;
        logic [7:0]        hist;
        logic [ONES_W-1:0] ones;
        logic [CNT_W-1:0]  cnt;
        logic              flag_q;
        logic              abort_q;
        logic              idle_q;
        logic              zero_q;
        logic              eof_q;
        logic              align_q;
        logic              ovf_q;

        logic [7:0]        hist_n;
        logic [CNT_W-1:0]  cnt_inc;
        logic              is_flag;
        logic              is_abort;
        logic              is_zero;
        logic              is_eof;
        logic              is_align;
        logic              is_idle;
        logic              ovf_set;

        always_comb begin
            hist_n   = {hist[6:0], Line[c]};
            is_flag  = BitEn[c] && (hist_n == 8'b0111_1110);
            is_abort = BitEn[c] && (hist_n == 8'b0111_1111);
            is_zero  = BitEn[c] && !Line[c] && (ones == ONES_W'(5)) && (state != HUNT);
            // Stuffed zeros are not counted; the count sticks at its maximum.
            cnt_inc  = (is_zero || (cnt == CNT_MAX)) ? cnt : cnt + CNT_W'(1);
            is_eof   = is_flag && (state == FRAME);
            // Count includes the closing flag, so payload alignment is cnt_inc mod 8.
            is_align = is_eof && (cnt_inc[2:0] != 3'b000);
            ovf_set  = BitEn[c] && (state == FRAME) && !is_flag && !is_abort
                       && (cnt_inc > CNT_LIMIT);
        end

`ifdef HDLC_MON_IDLE_EN
        // Runs modulo 15 so IdleDetect repeats on every further 15 ones.
        logic [3:0] idle_cnt;

        always_comb begin
            is_idle = BitEn[c] && Line[c] && (idle_cnt == 4'd14) && (state == HUNT);
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                idle_cnt <= '0;
            end else if (BitEn[c]) begin
                if (!Line[c] || (idle_cnt == 4'd14)) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 4'd1;
                end
            end
        end
`else
        assign is_idle = 1'b0;
`endif

        always_ff @(posedge Clk) begin
            if (Rst) begin
                state   <= HUNT;
                hist    <= '1;
                ones    <= '0;
                cnt     <= '0;
                flag_q  <= 1'b0;
                abort_q <= 1'b0;
                idle_q  <= 1'b0;
                zero_q  <= 1'b0;
                eof_q   <= 1'b0;
                align_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                flag_q  <= is_flag;
                abort_q <= is_abort;
                idle_q  <= is_idle;
                zero_q  <= is_zero;
                eof_q   <= is_eof;
                align_q <= is_align;
                // Kept through the edge that leaves FRAME, dropped on the next one.
                ovf_q   <= (state == FRAME) && (ovf_q || ovf_set);

                if (BitEn[c]) begin
                    hist <= hist_n;
                    if (!Line[c]) begin
                        ones <= '0;
                    end else if (ones != ONES_MAX) begin
                        ones <= ones + ONES_W'(1);
                    end

                    case (state)
                        HUNT: begin
                            if (is_flag) begin
                                state <= OPEN;
                                cnt   <= '0;
                            end
                        end
                        OPEN: begin
                            if (is_abort) begin
                                state <= HUNT;
                                cnt   <= '0;
                            end else if (is_flag) begin
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                                if (cnt_inc >= CNT_OPEN) begin
                                    state <= FRAME;
                                end
                            end
                        end
                        FRAME: begin
                            if (is_abort) begin
                                state <= HUNT;
                                cnt   <= '0;
                            end else if (is_flag) begin
                                state <= OPEN;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        default: begin
                            state <= HUNT;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        // At most one error event per line per bit: abort, flag and the
        // overflow set condition are mutually exclusive.
        assign err_ev[c] = (is_abort && (state == FRAME)) || (ovf_set && !ovf_q) || is_align;

        assign FlagDetect[c]  = flag_q;
        assign AbortDetect[c] = abort_q;
        assign IdleDetect[c]  = idle_q;
        assign ZeroDetect[c]  = zero_q;
        assign EoF[c]         = eof_q;
        assign AlignErr[c]    = align_q;
        assign ValidFrame[c]  = (state == FRAME);
        assign Overflow[c]    = ovf_q;
    end

    logic [SUM_W-1:0]       ev_sum;
    logic [ERR_W+SUM_W-1:0] err_ext;

    always_comb begin
        ev_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ev_sum = ev_sum + SUM_W'(err_ev[i]);
        end
        err_ext = {{SUM_W{1'b0}}, ErrCnt} + {{ERR_W{1'b0}}, ev_sum};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ErrCnt <= '0;
        end else if (err_ext[ERR_W+SUM_W-1:ERR_W] != '0) begin
            ErrCnt <= '1;
        end else begin
            ErrCnt <= err_ext[ERR_W-1:0];
        end
    end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb_hdlc_line_monitor
// Drives two lines bit by bit; a behavioural model predicts every cycle's
// outputs, pushes them on a queue, and a monitor pops and compares them after
// each clock edge. Scenario-level totals are also compared to hand-derived
// constants. A second instance with ERR_W=2 shares the stimulus.

module tb_hdlc_line_monitor;

    localparam int CH   = 2;
    localparam int MAXB = 4;
    localparam int LIM  = (MAXB + 1) * 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [CH-1:0] BitEn;
    logic [CH-1:0] Line;
    logic [CH-1:0] FlagDetect, AbortDetect, IdleDetect, ZeroDetect;
    logic [CH-1:0] EoF, AlignErr, ValidFrame, Overflow;
    logic [15:0]   ErrCnt;
    logic [CH-1:0] s_flag, s_abort, s_idle, s_zero, s_eof, s_align, s_valid, s_ovf;
    logic [1:0]    s_err;

    hdlc_line_monitor #(.CHANNELS(CH), .MAX_BYTES(MAXB), .ERR_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Line(Line),
        .FlagDetect(FlagDetect), .AbortDetect(AbortDetect), .IdleDetect(IdleDetect),
        .ZeroDetect(ZeroDetect), .EoF(EoF), .AlignErr(AlignErr),
        .ValidFrame(ValidFrame), .Overflow(Overflow), .ErrCnt(ErrCnt)
    );

    hdlc_line_monitor #(.CHANNELS(CH), .MAX_BYTES(MAXB), .ERR_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Line(Line),
        .FlagDetect(s_flag), .AbortDetect(s_abort), .IdleDetect(s_idle),
        .ZeroDetect(s_zero), .EoF(s_eof), .AlignErr(s_align),
        .ValidFrame(s_valid), .Overflow(s_ovf), .ErrCnt(s_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] ev;
        logic [15:0] err;
        logic [1:0]  err2;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   n_chk = 0;
    int   n_bad = 0;

    int   m_state[CH];   // 0 hunt, 1 open, 2 frame
    int   m_hist[CH];
    int   m_ones[CH];
    int   m_cnt[CH];
    bit   m_ovf[CH];
`ifdef HDLC_MON_IDLE_EN
    int   m_idle[CH];
`endif
    int   err_total = 0;

    int   bq[CH][$];     // 0/1 = strobed bit, 2 = no strobe
    int   flag_seen[CH], abort_seen[CH], zero_seen[CH], eof_seen[CH];
    int   align_seen[CH], idle_seen[CH], valid_cyc[CH], ovf_rise[CH];
    logic [CH-1:0] ovf_prev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle(input bit rst, input bit [CH-1:0] en, input bit [CH-1:0] b);
        logic [CH-1:0] f, a, i, z, e, al, v, o;
        exp_t x;
        int   nerr, h, n;
        bit   was_frame, set_ovf;
        f = '0; a = '0; i = '0; z = '0; e = '0; al = '0; v = '0; o = '0;
        nerr = 0;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_state[c] = 0; m_hist[c] = 255; m_ones[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0;
`ifdef HDLC_MON_IDLE_EN
                m_idle[c] = 0;
`endif
            end
            err_total = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                was_frame = (m_state[c] == 2);
                set_ovf   = 1'b0;
                if (en[c]) begin
                    h = ((m_hist[c] << 1) | int'(b[c])) & 255;
                    m_hist[c] = h;
                    f[c] = (h == 'h7E);
                    a[c] = (h == 'h7F);
                    z[c] = !b[c] && (m_ones[c] == 5) && (m_state[c] != 0);
`ifdef HDLC_MON_IDLE_EN
                    if (b[c]) begin
                        if (m_idle[c] == 14) begin
                            m_idle[c] = 0;
                            i[c] = (m_state[c] == 0);
                        end else begin
                            m_idle[c]++;
                        end
                    end else begin
                        m_idle[c] = 0;
                    end
`endif
                    m_ones[c] = b[c] ? m_ones[c] + 1 : 0;
                    n = z[c] ? m_cnt[c] : m_cnt[c] + 1;
                    if (a[c]) begin
                        if (was_frame) nerr++;
                        m_state[c] = 0;
                        m_cnt[c] = 0;
                    end else if (f[c]) begin
                        if (was_frame) begin
                            e[c] = 1'b1;
                            if ((n - 8) % 8 != 0) begin
                                al[c] = 1'b1;
                                nerr++;
                            end
                        end
                        m_state[c] = 1;
                        m_cnt[c] = 0;
                    end else if (m_state[c] == 1) begin
                        m_cnt[c] = n;
                        if (n >= 8) m_state[c] = 2;
                    end else if (m_state[c] == 2) begin
                        m_cnt[c] = n;
                        if (n > LIM) begin
                            set_ovf = 1'b1;
                            if (!m_ovf[c]) nerr++;
                        end
                    end
                end
                m_ovf[c] = was_frame && (m_ovf[c] || set_ovf);
                v[c] = (m_state[c] == 2);
                o[c] = m_ovf[c];
            end
            err_total += nerr;
        end
        x.ev   = {f, a, i, z, e, al, v, o};
        x.err  = (err_total > 65535) ? 16'hFFFF : 16'(err_total);
        x.err2 = (err_total > 3) ? 2'd3 : 2'(err_total);
        exp_q.push_back(x);
    endtask

    task automatic step(input bit rst, input bit [CH-1:0] en, input bit [CH-1:0] b);
        @(negedge Clk);
        Rst   = rst;
        BitEn = en;
        Line  = b;
        model_cycle(rst, en, b);
    endtask

    task automatic push_bits(input int c, input logic [31:0] val, input int nb);
        for (int k = nb - 1; k >= 0; k--) bq[c].push_back(int'(val[k]));
    endtask

    task automatic push_flag(input int c);
        push_bits(c, 32'h7E, 8);
    endtask

    task automatic push_gap(input int c, input int nb);
        for (int k = 0; k < nb; k++) bq[c].push_back(2);
    endtask

    task automatic run_streams();
        bit [CH-1:0] en, b;
        int v;
        while (bq[0].size() > 0 || bq[1].size() > 0) begin
            for (int c = 0; c < CH; c++) begin
                en[c] = 1'b0;
                b[c]  = 1'($urandom_range(0, 1));
                if (bq[c].size() > 0) begin
                    v = bq[c].pop_front();
                    if (v < 2) begin
                        en[c] = 1'b1;
                        b[c]  = v[0];
                    end
                end
            end
            step(1'b0, en, b);
        end
        repeat (3) step(1'b0, '0, '0);
    endtask

    task automatic clr_seen();
        for (int c = 0; c < CH; c++) begin
            flag_seen[c] = 0; abort_seen[c] = 0; zero_seen[c] = 0; eof_seen[c] = 0;
            align_seen[c] = 0; idle_seen[c] = 0; valid_cyc[c] = 0; ovf_rise[c] = 0;
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            chk("events", {FlagDetect, AbortDetect, IdleDetect, ZeroDetect,
                           EoF, AlignErr, ValidFrame, Overflow}, mon_x.ev);
            chk("events_sat", {s_flag, s_abort, s_idle, s_zero,
                               s_eof, s_align, s_valid, s_ovf}, mon_x.ev);
            chk("errcnt", ErrCnt, mon_x.err);
            chk("errcnt_sat", s_err, mon_x.err2);
        end
        for (int c = 0; c < CH; c++) begin
            flag_seen[c]  += int'(FlagDetect[c]);
            abort_seen[c] += int'(AbortDetect[c]);
            zero_seen[c]  += int'(ZeroDetect[c]);
            eof_seen[c]   += int'(EoF[c]);
            align_seen[c] += int'(AlignErr[c]);
            idle_seen[c]  += int'(IdleDetect[c]);
            valid_cyc[c]  += int'(ValidFrame[c]);
            ovf_rise[c]   += int'(Overflow[c] && !ovf_prev[c]);
        end
        ovf_prev = Overflow;
    end

    initial begin
        Rst = 1'b1; BitEn = '0; Line = '0;
        clr_seen();
        repeat (3) step(1'b1, '0, '0);
        @(posedge Clk); #2;
        chk("rst_valid", ValidFrame, '0);
        chk("rst_err", ErrCnt, '0);
        chk("rst_flag", FlagDetect, '0);

        // Flag, 16 data bits with a strobe gap, flag.
        clr_seen();
        push_flag(0); push_bits(0, 32'hA5, 8); push_gap(0, 3);
        push_bits(0, 32'h3C, 8); push_flag(0);
        run_streams();
        chk("s1_flags", flag_seen[0], 2);
        chk("s1_eof", eof_seen[0], 1);
        chk("s1_align", align_seen[0], 0);
        chk("s1_valid_cycles", valid_cyc[0], 19);
        chk("s1_err", ErrCnt, 0);

        // Stuffed payload 11111011 on ch0; back-to-back flags on ch1.
        clr_seen();
        push_flag(0); push_bits(0, 32'b1_1111_0011, 9); push_flag(0);
        push_flag(1); push_flag(1);
        run_streams();
        chk("s2_zero", zero_seen[0], 1);
        chk("s2_eof", eof_seen[0], 1);
        chk("s2_align", align_seen[0], 0);
        chk("s2_ch1_flags", flag_seen[1], 2);
        chk("s2_ch1_eof", eof_seen[1], 0);

        // Abort on ch1 inside a frame, then again while hunting.
        clr_seen();
        push_flag(1); push_bits(1, 32'hA5, 8); push_bits(1, 32'h3C, 8);
        push_bits(1, 32'h7F, 8); push_bits(1, 32'h7F, 8);
        run_streams();
        chk("s3_aborts", abort_seen[1], 2);
        chk("s3_err", ErrCnt, 1);
        chk("s3_valid", ValidFrame[1], 0);
        chk("s3_eof", eof_seen[1], 0);

        // Six-byte frame with MAX_BYTES=4.
        clr_seen();
        push_flag(0);
        push_bits(0, 32'hA53C5AC3, 32); push_bits(0, 32'h6996, 16);
        push_flag(0);
        run_streams();
        chk("s4_ovf_rise", ovf_rise[0], 1);
        chk("s4_eof", eof_seen[0], 1);
        chk("s4_err", ErrCnt, 2);
        chk("s4_ovf_clear", Overflow[0], 0);

        // Both lines close 12-bit payloads together, twice.
        for (int r = 0; r < 2; r++) begin
            clr_seen();
            for (int c = 0; c < CH; c++) begin
                push_flag(c); push_bits(c, 32'hA5, 8); push_bits(c, 32'b0011, 4); push_flag(c);
            end
            run_streams();
            chk("s5_align0", align_seen[0], 1);
            chk("s5_align1", align_seen[1], 1);
            chk("s5_err", ErrCnt, 4 + 2 * r);
            chk("s5_err_sat", s_err, 3);
        end

        // Reset mid-frame, then 15 ones on both lines.
        push_flag(0); push_bits(0, 32'hA5, 8); push_bits(0, 32'b10, 2);
        run_streams();
        chk("s6_pre_valid", ValidFrame[0], 1);
        clr_seen();
        step(1'b1, 2'b11, 2'b11);
        for (int c = 0; c < CH; c++) push_bits(c, 32'h7FFF, 15);
        run_streams();
        chk("s6_eof", eof_seen[0], 0);
        chk("s6_align", align_seen[0], 0);
        chk("s6_err", ErrCnt, 0);
        chk("s6_valid", ValidFrame, '0);
`ifdef HDLC_MON_IDLE_EN
        chk("s6_idle0", idle_seen[0], 1);
        chk("s6_idle1", idle_seen[1], 1);
`else
        chk("s6_idle0", idle_seen[0], 0);
        chk("s6_idle1", idle_seen[1], 0);
`endif

        @(posedge Clk); #2;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hdlc_line_monitor.md
HDLC_LINE_MONITOR -- requirements
Module: hdlc_line_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent serial HDLC lines monitored.
REQ-002 SHALL have parameter MAX_BYTES, default 128: largest legal frame payload in bytes.
REQ-003 SHALL have parameter ERR_W, default 16: width of the error counter.
REQ-004 SHALL have port Clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port Rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port BitEn  in  CHANNELS  per-channel bit strobe; the Line bit is sampled only when set.
REQ-007 SHALL have port Line  in  CHANNELS  per-channel serial data bit.
REQ-008 SHALL have ports FlagDetect, AbortDetect, IdleDetect, ZeroDetect, EoF, AlignErr  out  CHANNELS  each: one-cycle per-channel event pulses.
REQ-009 SHALL have port ValidFrame  out  CHANNELS  channel is in state FRAME.
REQ-010 SHALL have port Overflow  out  CHANNELS  sticky per-frame overflow flag.
REQ-011 SHALL have port ErrCnt  out  ERR_W  saturating count of error events across all channels.

Function
REQ-012 Each channel SHALL keep:
  - an 8-bit history of sampled bits;
  - a ones-run counter (saturating);
  - a destuffed-bit counter;
  - state HUNT/OPEN/FRAME.
REQ-013 All event outputs SHALL be registered, high exactly one cycle, starting the cycle after the sampling edge of the completing bit; no events while BitEn=0.
REQ-014 Flag = history 01111110 (newest bit 0), detected in any state.
REQ-015 Abort = seventh consecutive 1 preceded by 0; AbortDetect in any state.
REQ-016 ZeroDetect: a 0 after exactly five 1s, in OPEN or FRAME; that bit SHALL not increment the bit counter.
REQ-017 Transitions: HUNT+flag->OPEN (counter=0); OPEN+flag->OPEN (counter=0, no EoF); OPEN with counter reaching 8 and no flag->FRAME; FRAME+flag->OPEN with EoF; OPEN/FRAME+abort->HUNT.
REQ-018 On the closing flag, payload bits = counter-8; AlignErr SHALL pulse with EoF when payload bits mod 8 != 0.
REQ-019 Overflow SHALL set when counter exceeds (MAX_BYTES+1)*8 in FRAME; it holds until the channel leaves FRAME, cleared the cycle after leaving.
REQ-020 The counter SHALL saturate and never wrap.
REQ-021 Error events are: abort while in FRAME, Overflow rising, AlignErr. ErrCnt SHALL add the number of events occurring in a cycle (all channels), saturating at 2^ERR_W-1.
REQ-022 Flag and abort on the same bit are impossible; a flag completing while Overflow is set SHALL still produce EoF.

Reset
REQ-023 Rst SHALL put all channels in HUNT: history all-ones, counters 0, all outputs 0, ErrCnt 0, on the next edge.
REQ-024 Reset mid-frame SHALL emit no EoF, AlignErr or ErrCnt increment; Rst SHALL dominate BitEn.

Configuration
REQ-025 With HDLC_MON_IDLE_EN defined, IdleDetect SHALL pulse when the ones-run reaches 15 in HUNT, and once per further 15 ones.
REQ-026 Without HDLC_MON_IDLE_EN, IdleDetect SHALL be tied 0, and the ones-run counter SHALL saturate at 7.

Verification
REQ-027 Ch0 sends 01111110, then 16 data bits, then 01111110 -> FlagDetect twice; ValidFrame high from bit 8 after the opening flag; EoF=1, AlignErr=0, ErrCnt=0.
REQ-028 Payload 11111011 stuffed (0 after five 1s) -> ZeroDetect one cycle; frame payload counts 8 bits; no AlignErr.
REQ-029 In FRAME, ch1 sends 01111111 -> AbortDetect, ch1 returns to HUNT, ErrCnt=1. The same pattern in HUNT -> AbortDetect, ErrCnt unchanged.
REQ-030 MAX_BYTES=4, 6-byte frame -> Overflow rises at bit 41, holds until EoF; ErrCnt+1 only once.
REQ-031 Both channels close 12-bit-payload frames on the same cycle -> AlignErr on both; ErrCnt increments by 2; with ERR_W=2 and ErrCnt=3 it stays 3.
REQ-032 Rst asserted mid-frame; with HDLC_MON_IDLE_EN, 15 ones after reset -> no EoF, then IdleDetect one cycle after the 15th one.
